// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               Holds the loader FSM state encoding and the stream framing
//               constants (length-prefix size, bytes per instruction word).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader session states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Stream framing
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Width of the word-count prefix
    localparam int COUNT_WIDTH    = 8 * LEN_BYTES;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs a byte stream little-endian into one 32-bit word.
//               Each load writes byte_in into lane bidx, then bidx advances
//               modulo BYTES_PER_WORD. word_complete flags the load that
//               fills the last lane.
// Ports       : clk, reset     - clock / asynchronous active-high reset
//               clear          - return the lane index to 0 (start of image)
//               load           - byte_in is valid and must be stored
//               byte_in[7:0]   - incoming byte
//               word[31:0]     - assembled word (lane 0 in bits [7:0])
//               word_complete  - current load fills the final lane
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam int c_bidx_width = $clog2(BYTES_PER_WORD);

    logic [BYTES_PER_WORD-1:0][7:0] r_lanes;
    logic [c_bidx_width-1:0]        r_bidx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lanes <= '0;
            r_bidx  <= '0;
        end else if (clear) begin
            r_bidx  <= '0;
        end else if (load) begin
            r_lanes[r_bidx] <= byte_in;
            // Power-of-two lane count: natural wrap gives modulo behaviour
            r_bidx          <= r_bidx + 1'b1;
        end
    end

    assign word          = r_lanes;
    assign word_complete = load && (r_bidx == c_bidx_width'(BYTES_PER_WORD - 1));

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory writer. Receives a stream of a
//               16-bit little-endian word count N followed by 4*N bytes,
//               packs them into words and writes consecutive word addresses
//               starting at 0. The CPU core is held in reset until the whole
//               image has been written.
// Ports       : clk, reset          - clock / asynchronous active-high reset
//               start               - begin a session (IDLE, DONE, ERR only)
//               in_valid, in_data   - byte stream in
//               in_ready            - byte accepted when in_valid && in_ready
//               mem_we, mem_addr,
//               mem_wdata           - instruction-memory write port
//               cpu_hold            - keep core in reset
//               busy, done, error   - session status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Memory depth widened by one bit so N == DEPTH compares exactly
    localparam logic [COUNT_WIDTH:0] c_depth = (COUNT_WIDTH + 1)'(2 ** ADDR_WIDTH);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    // One extra bit so the pointer reaches DEPTH without wrapping to 0
    logic [ADDR_WIDTH:0]    r_wptr;
    logic [ADDR_WIDTH:0]    w_wptr_inc;

    logic                   w_xfer;
    logic [COUNT_WIDTH-1:0] w_len;
    logic                   w_asm_load;
    logic                   w_asm_clear;
    logic                   w_word_complete;
    logic [31:0]            w_word;

    assign w_xfer      = in_valid && in_ready;
    // Full count as it will be once the high byte lands this cycle
    assign w_len       = {in_data, r_count[7:0]};
    assign w_wptr_inc  = r_wptr + 1'b1;
    assign w_asm_load  = w_xfer && (r_state == ST_DATA);
    assign w_asm_clear = w_xfer && (r_state == ST_LEN1);

    word_assembler u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (w_asm_clear),
        .load          (w_asm_load),
        .byte_in       (in_data),
        .word          (w_word),
        .word_complete (w_word_complete)
    );

    // State, count and write pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_wptr  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer && (r_state == ST_LEN0)) begin
                r_count[7:0] <= in_data;
            end
            if (w_xfer && (r_state == ST_LEN1)) begin
                r_count[15:8] <= in_data;
                r_wptr        <= '0;
            end
            if (r_state == ST_WRITE) begin
                r_wptr <= w_wptr_inc;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_next = ST_LEN0;
                end
            end
            ST_LEN0: begin
                if (w_xfer) begin
                    w_state_next = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (w_xfer) begin
                    if (w_len == '0) begin
                        w_state_next = ST_DONE;
                    end else if ({1'b0, w_len} > c_depth) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_word_complete) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (COUNT_WIDTH'(w_wptr_inc) == r_count) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state / registers only
    always_comb begin
        in_ready = (r_state == ST_LEN0) || (r_state == ST_LEN1) || (r_state == ST_DATA);
        busy     = in_ready || (r_state == ST_WRITE);
        mem_we   = (r_state == ST_WRITE);
        cpu_hold = (r_state != ST_DONE);
        done     = (r_state == ST_DONE);
        error    = (r_state == ST_ERR);
    end

    assign mem_addr  = r_wptr[ADDR_WIDTH-1:0];
    assign mem_wdata = w_word;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Two instances: the
//               default 256-word configuration and a 4-word configuration
//               for the length-limit cases. Expected memory writes are
//               queued as images are streamed; per-instance monitors pop and
//               compare on every mem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [1:0]  in_valid;
    logic [7:0]  data0, data1;
    wire  [1:0]  in_ready, mem_we, cpu_hold, busy, done, error;
    wire  [7:0]  addr0;
    wire  [1:0]  addr1;
    wire  [31:0] wd0, wd1;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .in_valid(in_valid[0]), .in_data(data0), .in_ready(in_ready[0]),
        .mem_we(mem_we[0]), .mem_addr(addr0), .mem_wdata(wd0),
        .cpu_hold(cpu_hold[0]), .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    imem_loader #(.ADDR_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .in_valid(in_valid[1]), .in_data(data1), .in_ready(in_ready[1]),
        .mem_we(mem_we[1]), .mem_addr(addr1), .mem_wdata(wd1),
        .cpu_hold(cpu_hold[1]), .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q0[$];
    wr_t         q1[$];
    logic [31:0] img[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitors
    always @(negedge clk) begin
        wr_t e;
        if (mem_we[0] === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0 unexpected write: addr %0h data %08h", addr0, wd0);
            end else begin
                e = q0.pop_front();
                if (addr0 !== e.addr || wd0 !== e.data) begin
                    errors++;
                    $display("FAIL dut0 write: got addr %0h data %08h, expected addr %0h data %08h",
                             addr0, wd0, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (mem_we[1] === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1 unexpected write: addr %0h data %08h", addr1, wd1);
            end else begin
                e = q1.pop_front();
                if (addr1 !== e.addr[1:0] || wd1 !== e.data) begin
                    errors++;
                    $display("FAIL dut1 write: got addr %0h data %08h, expected addr %0h data %08h",
                             addr1, wd1, e.addr[1:0], e.data);
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            in_valid[0] = v;
            data0       = d;
        end else begin
            in_valid[1] = v;
            data1       = d;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer
    task automatic send_byte(input int sel, input logic [7:0] b);
        int n = 0;
        drive(sel, 1'b1, b);
        while (in_ready[sel] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: dut%0d in_ready 0, expected 1", sel);
        end
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic pulse_start(input int sel);
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
    endtask

    // Stream length n and n words from img[]; queue expected writes
    task automatic load(input int sel, input int n, input bit gap);
        logic [31:0] w;
        send_byte(sel, 8'(n));
        send_byte(sel, 8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = img[i];
            if (sel == 0) q0.push_back(wr_t'{8'(i), w});
            else          q1.push_back(wr_t'{8'(i), w});
            for (int k = 0; k < 4; k++) begin
                send_byte(sel, w[8*k +: 8]);
                if (gap) @(negedge clk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 2'b00;
        in_valid = 2'b00;
        data0    = 8'h00;
        data1    = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cpu_hold", 32'(cpu_hold[0]), 32'd1);
        check("rst_busy",     32'(busy[0]),     32'd0);
        check("rst_done",     32'(done[0]),     32'd0);
        check("rst_error",    32'(error[0]),    32'd0);
        check("rst_in_ready", 32'(in_ready[0]), 32'd0);
        check("rst_mem_we",   32'(mem_we[0]),   32'd0);
        check("rst_mem_addr", 32'(addr0),       32'd0);
        check("rst_wdata",    wd0,              32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic two-word image, continuous stream
        pulse_start(0);
        check("start_in_ready", 32'(in_ready[0]), 32'd1);
        check("start_busy",     32'(busy[0]),     32'd1);
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        load(0, 2, 1'b0);
        check("last_we",        32'(mem_we[0]),   32'd1);
        check("last_hold",      32'(cpu_hold[0]), 32'd1);
        @(negedge clk);
        check("done_hold",      32'(cpu_hold[0]), 32'd0);
        check("done_flag",      32'(done[0]),     32'd1);
        check("done_busy",      32'(busy[0]),     32'd0);

        // Restart from DONE, three words with gaps in in_valid
        pulse_start(0);
        check("restart_hold",   32'(cpu_hold[0]), 32'd1);
        check("restart_done",   32'(done[0]),     32'd0);
        check("restart_ready",  32'(in_ready[0]), 32'd1);
        img[0] = 32'h0403_0201;
        img[1] = 32'h0807_0605;
        img[2] = 32'hDDCC_BBAA;
        load(0, 3, 1'b1);
        repeat (2) @(negedge clk);
        check("gap_done",       32'(done[0]),     32'd1);

        // Zero-length image
        pulse_start(0);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        check("zero_done",      32'(done[0]),     32'd1);
        check("zero_hold",      32'(cpu_hold[0]), 32'd0);
        check("zero_we",        32'(mem_we[0]),   32'd0);

        // start while in DATA is ignored
        pulse_start(0);
        send_byte(0, 8'h01);
        send_byte(0, 8'h00);
        q0.push_back(wr_t'{8'h00, 32'hCAFE_F00D});
        send_byte(0, 8'h0D);
        send_byte(0, 8'hF0);
        pulse_start(0);
        check("ign_busy",       32'(busy[0]),     32'd1);
        check("ign_ready",      32'(in_ready[0]), 32'd1);
        send_byte(0, 8'hFE);
        send_byte(0, 8'hCA);
        @(negedge clk);
        check("ign_done",       32'(done[0]),     32'd1);

        // Reset after 6 data bytes of a two-word image
        pulse_start(0);
        send_byte(0, 8'h02);
        send_byte(0, 8'h00);
        q0.push_back(wr_t'{8'h00, 32'h4433_2211});
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        send_byte(0, 8'h44);
        send_byte(0, 8'h55);
        send_byte(0, 8'h66);
        reset = 1'b1;
        #1;
        check("mid_rst_hold",   32'(cpu_hold[0]), 32'd1);
        check("mid_rst_busy",   32'(busy[0]),     32'd0);
        check("mid_rst_done",   32'(done[0]),     32'd0);
        check("mid_rst_we",     32'(mem_we[0]),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_idle_hold", 32'(cpu_hold[0]), 32'd1);
        pulse_start(0);
        img[0] = 32'h1234_5678;
        img[1] = 32'h9ABC_DEF0;
        load(0, 2, 1'b0);
        @(negedge clk);
        check("reload_done",    32'(done[0]),     32'd1);

        // Small memory: N > DEPTH rejected
        pulse_start(1);
        send_byte(1, 8'h05);
        send_byte(1, 8'h00);
        check("err_flag",       32'(error[1]),    32'd1);
        check("err_hold",       32'(cpu_hold[1]), 32'd1);
        check("err_ready",      32'(in_ready[1]), 32'd0);
        check("err_busy",       32'(busy[1]),     32'd0);
        repeat (3) @(negedge clk);

        // Small memory: N == DEPTH fills 0..3 without wrapping
        pulse_start(1);
        check("err_clear",      32'(error[1]),    32'd0);
        check("err_restart_rdy", 32'(in_ready[1]), 32'd1);
        img[0] = 32'hA0A1_A2A3;
        img[1] = 32'hB0B1_B2B3;
        img[2] = 32'hC0C1_C2C3;
        img[3] = 32'hD0D1_D2D3;
        load(1, 4, 1'b0);
        @(negedge clk);
        check("full_done",      32'(done[1]),     32'd1);
        check("full_we",        32'(mem_we[1]),   32'd0);
        repeat (4) @(negedge clk);

        check("q0_drained",     32'(q0.size()),   32'd0);
        check("q1_drained",     32'(q1.size()),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
